// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1/2 stop bits, 3-sample voting.
// Define UART_RX_BREAK_EN to add break_det and swallow all-zero (break) frames.
module uart_rx_cfg #(
  parameter int unsigned CLOCK_HZ  = 10,
  parameter int unsigned BAUD_RATE = 1,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx,
  output logic                 valid,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
`ifdef UART_RX_BREAK_EN
  output logic                 break_det,
`endif
  output logic                 overrun
);

  localparam int unsigned CPB   = CLOCK_HZ / BAUD_RATE;
  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned BIT_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_VOTE  = CNT_W'(CPB / 2 + 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             PAR_EN    = (PARITY != 0);
  localparam logic             PAR_ODD   = (PARITY == 1);

  if (CPB < 4) begin : g_bad_cpb
    $error("uart_rx_cfg: CLOCK_HZ/BAUD_RATE must be >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  typedef struct packed {
    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 armed;
    logic [DATA_BITS-1:0] shift;
    logic                 par_err;
    logic                 frm_err;
`ifdef UART_RX_BREAK_EN
    logic                 all_zero;
    logic                 brk;
`endif
    logic                 valid;
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
  } regs_t;

  regs_t r;
  regs_t r_nxt;

  logic rx_meta;
  logic srx;
  logic srx_d1;
  logic srx_d2;
  logic vote_c;
  logic at_vote_c;
  logic complete_c;
  logic is_break_c;
  logic frm_final_c;

  // Two-flop synchroniser plus two history taps for the 3-sample vote.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      srx     <= 1'b1;
      srx_d1  <= 1'b1;
      srx_d2  <= 1'b1;
    end else begin
      rx_meta <= rx;
      srx     <= rx_meta;
      srx_d1  <= srx;
      srx_d2  <= srx_d1;
    end
  end

  // When cnt hits CNT_VOTE, srx_d1 holds the centre sample and srx/srx_d2 its neighbours.
  assign vote_c    = (srx & srx_d1) | (srx & srx_d2) | (srx_d1 & srx_d2);
  assign at_vote_c = (r.cnt == CNT_VOTE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r <= '0;
    end else begin
      r <= r_nxt;
    end
  end

  always_comb begin
    r_nxt       = r;
    complete_c  = 1'b0;
    is_break_c  = 1'b0;
    frm_final_c = r.frm_err | ~vote_c;
    r_nxt.overrun = 1'b0;
`ifdef UART_RX_BREAK_EN
    r_nxt.brk = 1'b0;
`endif
    r_nxt.cnt = (r.cnt == CNT_LAST) ? '0 : r.cnt + CNT_W'(1);
    if (r.valid && ready) begin
      r_nxt.valid = 1'b0;
    end

    case (r.state)
      S_IDLE: begin
        if (srx) begin
          r_nxt.armed = 1'b1;
        end
        // armed only sets on a high line, so a stuck-low line cannot retrigger.
        if (r.armed && !srx) begin
          r_nxt.armed = 1'b0;
          r_nxt.state = S_START;
          r_nxt.cnt   = '0;
        end
      end
      S_START: begin
        if (at_vote_c) begin
          if (vote_c) begin
            r_nxt.state = S_IDLE;
          end else begin
            r_nxt.state   = S_DATA;
            r_nxt.bit_cnt = '0;
            r_nxt.par_err = 1'b0;
            r_nxt.frm_err = 1'b0;
`ifdef UART_RX_BREAK_EN
            r_nxt.all_zero = 1'b1;
`endif
          end
        end
      end
      S_DATA: begin
        if (at_vote_c) begin
          r_nxt.shift = {vote_c, r.shift[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_EN
          if (vote_c) r_nxt.all_zero = 1'b0;
`endif
          if (r.bit_cnt == DATA_LAST) begin
            r_nxt.bit_cnt = '0;
            r_nxt.state   = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            r_nxt.bit_cnt = r.bit_cnt + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (at_vote_c) begin
          r_nxt.par_err = ((^r.shift) ^ vote_c) != PAR_ODD;
          r_nxt.bit_cnt = '0;
          r_nxt.state   = S_STOP;
`ifdef UART_RX_BREAK_EN
          if (vote_c) r_nxt.all_zero = 1'b0;
`endif
        end
      end
      S_STOP: begin
        if (at_vote_c) begin
          r_nxt.frm_err = frm_final_c;
`ifdef UART_RX_BREAK_EN
          if (vote_c) r_nxt.all_zero = 1'b0;
`endif
          if (r.bit_cnt == STOP_LAST) begin
            r_nxt.bit_cnt = '0;
            r_nxt.state   = S_IDLE;
            complete_c    = 1'b1;
          end else begin
            r_nxt.bit_cnt = r.bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        r_nxt.state = S_IDLE;
      end
    endcase

`ifdef UART_RX_BREAK_EN
    is_break_c = complete_c && r.all_zero && !vote_c;
    if (is_break_c) begin
      r_nxt.brk = 1'b1;
    end
`endif

    // Deliver into a free (or simultaneously drained) slot, otherwise drop and flag overrun.
    if (complete_c && !is_break_c) begin
      if (!r.valid || ready) begin
        r_nxt.valid      = 1'b1;
        r_nxt.data       = r.shift;
        r_nxt.parity_err = r.par_err;
        r_nxt.frame_err  = frm_final_c;
      end else begin
        r_nxt.overrun = 1'b1;
      end
    end
  end

  assign valid      = r.valid;
  assign data       = r.data;
  assign parity_err = r.parity_err;
  assign frame_err  = r.frame_err;
  assign overrun    = r.overrun;
`ifdef UART_RX_BREAK_EN
  assign break_det  = r.brk;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: three configurations (8N1, 8E2, 5O1 at 4 clocks/bit).
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] rx;
  logic [2:0] rdy;
  wire  [2:0] vld;
  wire  [2:0] pe;
  wire  [2:0] fe;
  wire  [2:0] ov;
  wire  [7:0] dat_a;
  wire  [7:0] dat_b;
  wire  [4:0] dat_c;
`ifdef UART_RX_BREAK_EN
  wire  [2:0] brk;
  int         brk_cnt [3];
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int ov_cnt [3];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLOCK_HZ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .resetn(resetn), .rx(rx[0]), .valid(vld[0]), .ready(rdy[0]), .data(dat_a),
    .parity_err(pe[0]), .frame_err(fe[0]),
`ifdef UART_RX_BREAK_EN
    .break_det(brk[0]),
`endif
    .overrun(ov[0]));

  uart_rx_cfg #(.CLOCK_HZ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .resetn(resetn), .rx(rx[1]), .valid(vld[1]), .ready(rdy[1]), .data(dat_b),
    .parity_err(pe[1]), .frame_err(fe[1]),
`ifdef UART_RX_BREAK_EN
    .break_det(brk[1]),
`endif
    .overrun(ov[1]));

  uart_rx_cfg #(.CLOCK_HZ(9), .BAUD_RATE(2), .DATA_BITS(5), .PARITY(1), .STOP_BITS(1)) u_c (
    .clk(clk), .resetn(resetn), .rx(rx[2]), .valid(vld[2]), .ready(rdy[2]), .data(dat_c),
    .parity_err(pe[2]), .frame_err(fe[2]),
`ifdef UART_RX_BREAK_EN
    .break_det(brk[2]),
`endif
    .overrun(ov[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i]) ov_cnt[i] <= ov_cnt[i] + 1;
`ifdef UART_RX_BREAK_EN
      if (brk[i]) brk_cnt[i] <= brk_cnt[i] + 1;
`endif
    end
  end

  function automatic int cpb_of(input int i);
    case (i)
      0:       return 16;
      1:       return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int nb_of(input int i);
    return (i == 2) ? 5 : 8;
  endfunction

  function automatic int par_of(input int i);
    case (i)
      0:       return 0;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int stop_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic logic [8:0] dat_of(input int i);
    case (i)
      0:       return {1'b0, dat_a};
      1:       return {1'b0, dat_b};
      default: return {4'b0, dat_c};
    endcase
  endfunction

  // Reference model: parity error when the count of ones in data+parity has the wrong oddness.
  function automatic logic model_pe(input int inst, input logic [8:0] d, input logic pbit);
    int ones;
    ones = 0;
    if (par_of(inst) == 0) return 1'b0;
    for (int i = 0; i < nb_of(inst); i++) ones += int'(d[i]);
    ones += int'(pbit);
    return ((ones % 2) == 1) != (par_of(inst) == 1);
  endfunction

  function automatic logic model_fe(input int inst, input logic [1:0] stops);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < stop_of(inst); i++) if (!stops[i]) bad = 1'b1;
    return bad;
  endfunction

  task automatic cmp(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input int inst, input logic b);
    rx[inst] = b;
    repeat (cpb_of(inst)) @(negedge clk);
  endtask

  task automatic idle(input int inst, input int n);
    rx[inst] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int inst, input logic [8:0] d, input logic pbit,
                            input logic [1:0] stops);
    drive_bit(inst, 1'b0);
    for (int i = 0; i < nb_of(inst); i++) drive_bit(inst, d[i]);
    if (par_of(inst) != 0) drive_bit(inst, pbit);
    for (int i = 0; i < stop_of(inst); i++) drive_bit(inst, stops[i]);
  endtask

  task automatic check_word(input int inst, input logic [8:0] ed, input logic epe,
                            input logic efe, input string name);
    int n;
    n = 0;
    while (vld[inst] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    cmp({name, " valid"}, 9'(vld[inst]), 9'd1);
    cmp({name, " data"}, dat_of(inst), ed);
    cmp({name, " parity_err"}, 9'(pe[inst]), 9'(epe));
    cmp({name, " frame_err"}, 9'(fe[inst]), 9'(efe));
  endtask

  task automatic accept(input int inst, input string name);
    rdy[inst] = 1'b1;
    @(negedge clk);
    rdy[inst] = 1'b0;
    cmp({name, " valid drop"}, 9'(vld[inst]), 9'd0);
  endtask

  typedef struct {
    int         inst;
    logic [8:0] d;
    logic       pbit;
    logic [1:0] stops;
    logic [8:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int         inst;
    int         base;
    logic [8:0] d;
    logic [8:0] mask;
    logic       pbit;
    logic [1:0] stops;
    logic       stable;

    vecs[0]  = '{0, 9'h03C, 1'b0, 2'b00, 9'h03C, 1'b0, 1'b1};
    vecs[1]  = '{0, 9'h0FF, 1'b0, 2'b01, 9'h0FF, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h000, 1'b0, 2'b01, 9'h000, 1'b0, 1'b0};
    vecs[3]  = '{1, 9'h007, 1'b0, 2'b11, 9'h007, 1'b1, 1'b0};
    vecs[4]  = '{1, 9'h007, 1'b1, 2'b11, 9'h007, 1'b0, 1'b0};
    vecs[5]  = '{1, 9'h05A, 1'b0, 2'b01, 9'h05A, 1'b0, 1'b1};
    vecs[6]  = '{1, 9'h0FF, 1'b0, 2'b10, 9'h0FF, 1'b0, 1'b1};
    vecs[7]  = '{1, 9'h080, 1'b0, 2'b11, 9'h080, 1'b1, 1'b0};
    vecs[8]  = '{2, 9'h015, 1'b0, 2'b01, 9'h015, 1'b0, 1'b0};
    vecs[9]  = '{2, 9'h015, 1'b1, 2'b01, 9'h015, 1'b1, 1'b0};
    vecs[10] = '{2, 9'h000, 1'b1, 2'b01, 9'h000, 1'b0, 1'b0};
    vecs[11] = '{2, 9'h01F, 1'b0, 2'b00, 9'h01F, 1'b0, 1'b1};

    resetn = 1'b0;
    rx     = 3'b111;
    rdy    = 3'b000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("reset flags %0d", i), {5'b0, vld[i], pe[i], fe[i], ov[i]}, 9'd0);
      cmp($sformatf("reset data %0d", i), dat_of(i), 9'd0);
    end
    resetn = 1'b1;
    repeat (8) @(negedge clk);

    // 0xA5 held with ready low, then drained.
    send_frame(0, 9'h0A5, 1'b0, 2'b01);
    idle(0, 32);
    check_word(0, 9'h0A5, 1'b0, 1'b0, "a5");
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (vld[0] !== 1'b1 || dat_a !== 8'hA5 || pe[0] !== 1'b0 || fe[0] !== 1'b0) stable = 1'b0;
    end
    cmp("a5 hold 50", 9'(stable), 9'd1);
    accept(0, "a5");

    for (int k = 0; k < 12; k++) begin
      inst = vecs[k].inst;
      send_frame(inst, vecs[k].d, vecs[k].pbit, vecs[k].stops);
      idle(inst, 2 * cpb_of(inst));
      check_word(inst, vecs[k].ed, vecs[k].epe, vecs[k].efe, $sformatf("vec%0d", k));
      accept(inst, $sformatf("vec%0d", k));
    end

    // Stop bit low, line stays low: exactly one frame.
    base = ov_cnt[0];
    send_frame(0, 9'h03C, 1'b0, 2'b00);
    repeat (40) @(negedge clk);
    check_word(0, 9'h03C, 1'b0, 1'b1, "stuck");
    accept(0, "stuck");
    repeat (400) @(negedge clk);
    cmp("stuck no second frame", 9'(vld[0]), 9'd0);
    cmp("stuck no overrun", 9'(ov_cnt[0] - base), 9'd0);
    idle(0, 48);
    send_frame(0, 9'h055, 1'b0, 2'b01);
    idle(0, 32);
    check_word(0, 9'h055, 1'b0, 1'b0, "after stuck");
    accept(0, "after stuck");

    // Three-clock glitch must be rejected.
    rx[0] = 1'b0;
    repeat (3) @(negedge clk);
    idle(0, 250);
    cmp("glitch no valid", 9'(vld[0]), 9'd0);
    send_frame(0, 9'h055, 1'b0, 2'b01);
    idle(0, 32);
    check_word(0, 9'h055, 1'b0, 1'b0, "after glitch");
    accept(0, "after glitch");

    // Back-to-back frames with ready low: second dropped, one overrun pulse.
    base = ov_cnt[0];
    send_frame(0, 9'h011, 1'b0, 2'b01);
    send_frame(0, 9'h022, 1'b0, 2'b01);
    idle(0, 40);
    check_word(0, 9'h011, 1'b0, 1'b0, "overrun keep");
    cmp("overrun pulse count", 9'(ov_cnt[0] - base), 9'd1);
    accept(0, "overrun");

    // Reset during bit 4 of a frame while a word is pending.
    send_frame(0, 9'h033, 1'b0, 2'b01);
    idle(0, 32);
    check_word(0, 9'h033, 1'b0, 1'b0, "pre reset");
    d = 9'h081;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
    rx[0] = d[4];
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    cmp("midreset flags", {5'b0, vld[0], pe[0], fe[0], ov[0]}, 9'd0);
    cmp("midreset data", dat_of(0), 9'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    idle(0, 300);
    cmp("midreset partial dropped", 9'(vld[0]), 9'd0);
    send_frame(0, 9'h081, 1'b0, 2'b01);
    idle(0, 32);
    check_word(0, 9'h081, 1'b0, 1'b0, "post reset");
    accept(0, "post reset");

    // All-zero frame: break when enabled, otherwise data 0 with frame error.
    send_frame(0, 9'h000, 1'b0, 2'b00);
`ifdef UART_RX_BREAK_EN
    base = brk_cnt[0];
    idle(0, 48);
    cmp("break no valid", 9'(vld[0]), 9'd0);
    cmp("break pulse count", 9'(brk_cnt[0] - base), 9'd1);
`else
    idle(0, 48);
    check_word(0, 9'h000, 1'b0, 1'b1, "break as data");
    accept(0, "break as data");
`endif

    // Randomised frames against the reference model.
    for (int k = 0; k < 60; k++) begin
      inst  = k % 3;
      mask  = 9'((1 << nb_of(inst)) - 1);
      d     = 9'($urandom) & mask;
      pbit  = 1'($urandom_range(0, 1));
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
`ifdef UART_RX_BREAK_EN
      if (d == 9'd0 && (pbit == 1'b0 || par_of(inst) == 0)) stops[0] = 1'b1;
`endif
      send_frame(inst, d, pbit, stops);
      idle(inst, 2 * cpb_of(inst));
      check_word(inst, d, model_pe(inst, d, pbit), model_fe(inst, stops), $sformatf("rnd%0d", k));
      accept(inst, $sformatf("rnd%0d", k));
    end

    @(negedge clk);
    cmp("total overruns a", 9'(ov_cnt[0]), 9'd1);
    cmp("total overruns b", 9'(ov_cnt[1]), 9'd0);
    cmp("total overruns c", 9'(ov_cnt[2]), 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
